serial_frame_receive: RTL and testbench

Parametrised successor to the fixed 64-byte serial input stage. It consumes the byte stream from `async_receiver` and hunts for a sync byte. It then collects a configurable number of payload bytes, verifies an XOR checksum, and commits the frame atomically to a held output register. It adds the following, which the fixed stage lacks:
- framing;
- error detection;
- inter-byte timeout resynchronisation;
- reset.

It sits between `async_receiver` and the hashing core, which reads `payload` as midstate/data.

---
 rtl/serial_pkg.sv | 8 +
 rtl/serial_frame_receive.sv | 131 +++++++++++++
 tb/tb_serial_frame_receive.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: states, error codes and defaults shared by the serial frame receive/transmit blocks.
package serial_pkg;
   typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;
   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_CSUM    = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/serial_frame_receive.sv
// serial_frame_receive: sync hunt, payload collection, XOR check and atomic commit of byte-stream frames.
module serial_frame_receive
   import serial_pkg::*;
#(
   parameter int         CLK_FRQ        = 50_000_000,
   parameter int         PAYLOAD_BYTES  = 64,
   parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
   parameter int         TIMEOUT_CYCLES = 50_000,
   parameter bit         CHECK_EN       = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [7:0]                 rx_data,
   input  logic                       rx_valid,
   output logic [8*PAYLOAD_BYTES-1:0] payload,
   output logic                       frame_valid,
   output logic                       frame_err,
   output logic [1:0]                 err_code,
   output logic                       busy,
   output logic [15:0]                ok_count,
   output logic [15:0]                err_count
);
   localparam int BW = 8*PAYLOAD_BYTES;
   localparam int IW = $clog2(PAYLOAD_BYTES+1);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [IW-1:0] LAST_IDX = IW'(PAYLOAD_BYTES-1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES-1);

   if (PAYLOAD_BYTES < 1 || PAYLOAD_BYTES > 256 || TIMEOUT_CYCLES < 2 || CLK_FRQ <= 0) begin : g_bad_param
      $error("serial_frame_receive: illegal parameter value");
   end

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [BW-1:0]   buf_q, buf_d, payload_q, payload_d, shifted;
   logic [7:0]      acc_q, acc_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            fv_q, fv_d, fe_q, fe_d;
   logic [1:0]      code_q, code_d;
   logic [15:0]     ok_q, ok_d, ec_q, ec_d;

   assign shifted = (buf_q << 8) | BW'(rx_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= HUNT;
         idx_q     <= '0;
         buf_q     <= '0;
         acc_q     <= '0;
         tmo_q     <= '0;
         payload_q <= '0;
         fv_q      <= 1'b0;
         fe_q      <= 1'b0;
         code_q    <= ERR_NONE;
         ok_q      <= '0;
         ec_q      <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         buf_q     <= buf_d;
         acc_q     <= acc_d;
         tmo_q     <= tmo_d;
         payload_q <= payload_d;
         fv_q      <= fv_d;
         fe_q      <= fe_d;
         code_q    <= code_d;
         ok_q      <= ok_d;
         ec_q      <= ec_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      buf_d     = buf_q;
      acc_d     = acc_q;
      tmo_d     = tmo_q;
      payload_d = payload_q;
      fv_d      = 1'b0;
      fe_d      = 1'b0;
      code_d    = code_q;
      ok_d      = ok_q;
      ec_d      = ec_q;
      if (state_q == HUNT) begin
         if (rx_valid && rx_data == SYNC_BYTE) begin
            state_d = PAYLOAD;
            idx_d   = '0;
            buf_d   = '0;
            acc_d   = '0;
            tmo_d   = '0;
         end
      end else if (rx_valid) begin
         // an arriving byte always beats a timeout reached in the same cycle
         tmo_d = '0;
         if (state_q == PAYLOAD) begin
            buf_d = shifted;
            acc_d = acc_q ^ rx_data;
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d   = CHECK_EN ? CHECK : HUNT;
               payload_d = CHECK_EN ? payload_q : shifted;
               fv_d      = !CHECK_EN;
               ok_d      = CHECK_EN ? ok_q : ok_q + 16'd1;
            end
         end else begin
            state_d   = HUNT;
            payload_d = (rx_data == acc_q) ? buf_q : payload_q;
            fv_d      = (rx_data == acc_q);
            fe_d      = (rx_data != acc_q);
            ok_d      = (rx_data == acc_q) ? ok_q + 16'd1 : ok_q;
            ec_d      = (rx_data == acc_q) ? ec_q : ec_q + 16'd1;
            code_d    = (rx_data == acc_q) ? code_q : ERR_CSUM;
         end
      end else if (tmo_q == TMO_LAST) begin
         state_d = HUNT;
         fe_d    = 1'b1;
         code_d  = ERR_TIMEOUT;
         ec_d    = ec_q + 16'd1;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   assign payload     = payload_q;
   assign frame_valid = fv_q;
   assign frame_err   = fe_q;
   assign err_code    = code_q;
   assign busy        = (state_q != HUNT);
   assign ok_count    = ok_q;
   assign err_count   = ec_q;
endmodule

// File: tb/tb_serial_frame_receive.sv
// tb_serial_frame_receive: scenario table, hand sequences and random frames checked against a queue-based frame model.
module tb_serial_frame_receive;
   localparam int PB = 4;
   localparam int TO = 100;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic [8*PB-1:0] payload;
   logic          frame_valid, frame_err, busy;
   logic [1:0]    err_code;
   logic [15:0]   ok_count, err_count;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   serial_frame_receive #(
      .CLK_FRQ(50_000_000), .PAYLOAD_BYTES(PB), .SYNC_BYTE(8'hA5),
      .TIMEOUT_CYCLES(TO), .CHECK_EN(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .payload(payload), .frame_valid(frame_valid), .frame_err(frame_err),
      .err_code(err_code), .busy(busy), .ok_count(ok_count), .err_count(err_count)
   );

   // Reference: a frame is a sync byte, PB data bytes collected in a queue, then their XOR.
   logic [7:0]  q[$];
   bit          m_in = 1'b0;
   int          idle = 0;
   logic [31:0] m_pl = '0;
   logic        m_fv = 1'b0, m_fe = 1'b0;
   logic [1:0]  m_code = 2'b00;
   logic [15:0] m_ok = '0, m_ec = '0;

   function automatic logic [7:0] q_xor();
      logic [7:0] x = 8'h00;
      foreach (q[i]) x ^= q[i];
      return x;
   endfunction

   function automatic logic [31:0] q_pack();
      logic [31:0] p = '0;
      foreach (q[i]) p = (p << 8) | 32'(q[i]);
      return p;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_in = 1'b0; idle = 0; m_pl = '0; m_fv = 1'b0; m_fe = 1'b0;
         m_code = 2'b00; m_ok = '0; m_ec = '0;
      end else begin
         m_fv = 1'b0;
         m_fe = 1'b0;
         if (!m_in) begin
            if (rx_valid && rx_data == 8'hA5) begin
               m_in = 1'b1; q.delete(); idle = 0;
            end
         end else if (rx_valid) begin
            idle = 0;
            if (q.size() < PB) q.push_back(rx_data);
            else begin
               m_in = 1'b0;
               if (q_xor() == rx_data) begin
                  m_pl = q_pack(); m_fv = 1'b1; m_ok++;
               end else begin
                  m_fe = 1'b1; m_code = 2'b01; m_ec++;
               end
            end
         end else begin
            idle++;
            if (idle == TO) begin
               m_in = 1'b0; m_fe = 1'b1; m_code = 2'b10; m_ec++;
            end
         end
      end
   end

   task automatic cmp();
      checks++;
      if ({payload, frame_valid, frame_err, err_code, busy, ok_count, err_count} !==
          {m_pl, m_fv, m_fe, m_code, m_in, m_ok, m_ec}) begin
         errors++;
         if (errors < 20)
            $display("FAIL model t=%0t got pl=%h fv=%b fe=%b code=%b busy=%b ok=%0d ec=%0d want pl=%h fv=%b fe=%b code=%b busy=%b ok=%0d ec=%0d",
                     $time, payload, frame_valid, frame_err, err_code, busy, ok_count, err_count,
                     m_pl, m_fv, m_fe, m_code, m_in, m_ok, m_ec);
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d);
      @(negedge clk);
      cmp();
      rx_valid = v;
      rx_data  = d;
   endtask

   task automatic send(input logic [7:0] d);
      step(1'b1, d);
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00);
   endtask

   typedef struct {
      int          n;
      logic [71:0] b;
      logic [31:0] pl;
      logic [15:0] ok;
      logic [15:0] ec;
      logic [1:0]  code;
   } vec_t;
   vec_t tbl[4];

   initial begin
      tbl[0] = '{6, {8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 24'h0}, 32'h11223344, 16'd1, 16'd0, 2'b00};
      tbl[1] = '{6, {8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45, 24'h0}, 32'h11223344, 16'd1, 16'd1, 2'b01};
      tbl[2] = '{9, {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22}, 32'hDEADBEEF, 16'd2, 16'd1, 2'b01};
      tbl[3] = '{6, {8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5, 24'h0}, 32'hA5000000, 16'd3, 16'd1, 2'b01};
      repeat (3) @(posedge clk);
      idle_n(1);
      chk("reset_state", {payload, frame_valid, frame_err, err_code, busy, ok_count, err_count}, '0);
      rst_n = 1'b1;
      idle_n(2);

      // scenario 1 latency: nothing yet on the sampling edge, pulse one edge later
      for (int i = 0; i < 6; i++) send(tbl[0].b[71-8*i -: 8]);
      step(1'b0, 8'h00);
      chk("s1_fv_one_edge", {63'd0, frame_valid}, 64'd1);
      chk("s1_payload", 64'(payload), 64'h11223344);
      step(1'b0, 8'h00);
      chk("s1_fv_single", {63'd0, frame_valid}, 64'd0);
      for (int t = 1; t < 4; t++) begin
         for (int i = 0; i < tbl[t].n; i++) send(tbl[t].b[71-8*i -: 8]);
         idle_n(2);
         chk($sformatf("table%0d", t), {payload, ok_count, err_count, err_code},
             {tbl[t].pl, tbl[t].ok, tbl[t].ec, tbl[t].code});
      end

      // timeout after exactly TO idle cycles
      send(8'hA5); send(8'h11); send(8'h22);
      idle_n(TO);
      chk("tmo_not_early", {62'd0, frame_err, busy}, 64'd1);
      idle_n(1);
      chk("tmo_fire", {60'd0, frame_err, err_code, busy}, {60'd0, 1'b1, 2'b10, 1'b0});
      chk("tmo_count", 64'(err_count), 64'd2);
      for (int i = 0; i < 6; i++) send(tbl[0].b[71-8*i -: 8]);
      idle_n(2);
      chk("after_tmo_frame", {payload, ok_count}, {32'h11223344, 16'd4});

      // a byte on the cycle the count is reached wins
      send(8'hA5);
      idle_n(TO - 1);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h04);
      idle_n(2);
      chk("byte_wins", {payload, ok_count, err_count}, {32'h01020304, 16'd5, 16'd2});

      // reset mid-frame
      send(8'hA5); send(8'h11);
      step(1'b0, 8'h00);
      chk("busy_mid_frame", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      idle_n(1);
      chk("reset_mid_frame", {payload, frame_valid, frame_err, err_code, busy, ok_count, err_count}, '0);
      rst_n = 1'b1;
      send(8'hA5); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h04);
      idle_n(2);
      chk("post_reset_frame", {payload, ok_count, err_count}, {32'h01020304, 16'd1, 16'd0});

      // random frames with garbage, gaps, bad checksums and occasional timeouts
      for (int f = 0; f < 300; f++) begin
         logic [7:0] x;
         x = 8'h00;
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) send(8'($urandom));
         send(8'hA5);
         for (int i = 0; i < PB + 1; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            if ($urandom_range(0, 39) == 0) idle_n($urandom_range(TO - 2, TO + 3));
            else if ($urandom_range(0, 2) == 0) idle_n($urandom_range(1, 3));
            if (i == PB) d = ($urandom_range(0, 3) == 0) ? d : x;
            x ^= d;
            send(d);
         end
         if ($urandom_range(0, 1) == 0) idle_n($urandom_range(0, 3));
      end
      idle_n(TO + 2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
